lighthouse_report_scheduler: RTL and testbench

//  Shares one byte-wide output stream (UART/USB TX) between the two lighthouse sensor event sources.

---
 rtl/lighthouse_report_scheduler_pkg.sv | 27 ++
 rtl/lighthouse_report_scheduler_if.sv | 21 ++
 rtl/lighthouse_report_scheduler_angle_fifo.sv | 56 +++++
 rtl/lighthouse_report_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_lighthouse_report_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lighthouse_report_scheduler_pkg.sv
// Lighthouse report scheduler: shared constants, packet framing, FSM types.
// Imported by the scheduler top and its angle FIFO.
package lighthouse_report_pkg;

  localparam logic [1:0] PKT_ANGLE = 2'b10;
  localparam logic [1:0] PKT_OOTX  = 2'b11;

  localparam int ANGLE_LEN = 4;
  localparam int OOTX_LEN  = 2;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  typedef enum logic {
    G_ANGLE,
    G_OOTX
  } grant_e;

  function automatic logic [7:0] ootx_hdr(
    input logic lh
  );
    return {PKT_OOTX, lh, 5'b0};
  endfunction

endpackage

// File: rtl/lighthouse_report_scheduler_if.sv
// Byte-wide valid/ready stream toward the serial transmitter.
// master: drives out_data/out_valid, samples out_ready; slave: the sink.
interface lighthouse_report_scheduler_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/lighthouse_report_scheduler_angle_fifo.sv
// Single-clock show-ahead FIFO for angle samples.
// Ports: wr_en/din push, rd_en pops, dout valid while !empty; full/empty flags.
module lighthouse_angle_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer MSB tells full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Full is judged before any same-cycle pop, so a write while full drops.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/lighthouse_report_scheduler.sv
// Merges angle samples and OOTX bits into framed packets on one byte stream.
// Ports: clk, reset, angle/OOTX strobes+fields, tx (byte stream master), drop_count, ootx_overrun.
module lighthouse_report_scheduler
  import lighthouse_report_pkg::*;
#(
  parameter int SENSORS     = 1,
  parameter int SENSOR_BITS = 4,
  parameter int ANGLE_BITS  = 20,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   angle_strobe,
  input  logic [ANGLE_BITS-1:0]  angle,
  input  logic [SENSOR_BITS-1:0] sensor,
  input  logic                   lighthouse,
  input  logic                   axis,
  input  logic                   data_strobe,
  input  logic                   data,
  lighthouse_report_scheduler_if.master tx,
  output logic [7:0]             drop_count,
  output logic                   ootx_overrun
);

  localparam int EW = 2 + SENSOR_BITS + ANGLE_BITS;

  if (SENSOR_BITS < 1 || SENSOR_BITS > 4) begin : g_bad_sensor_bits
    $error("SENSOR_BITS must be 1..4");
  end
  if (SENSORS < 1 || SENSORS > (1 << SENSOR_BITS)) begin : g_bad_sensors
    $error("SENSORS must fit in SENSOR_BITS");
  end
  if (ANGLE_BITS < 1 || ANGLE_BITS > 24) begin : g_bad_angle_bits
    $error("ANGLE_BITS must be 1..24");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  // ---------------- angle path ----------------
  logic [EW-1:0]          fifo_din;
  logic [EW-1:0]          fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_rd;
  logic                   f_lh;
  logic                   f_axis;
  logic [SENSOR_BITS-1:0] f_sensor;
  logic [ANGLE_BITS-1:0]  f_angle;
  logic [3:0]             f_s4;
  logic [23:0]            f_a24;

  assign fifo_din = {lighthouse, axis, sensor, angle};

  lighthouse_angle_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (angle_strobe),
    .din   (fifo_din),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign f_lh     = fifo_dout[EW-1];
  assign f_axis   = fifo_dout[EW-2];
  assign f_sensor = fifo_dout[ANGLE_BITS +: SENSOR_BITS];
  assign f_angle  = fifo_dout[ANGLE_BITS-1:0];

  always_comb begin
    f_s4  = '0;
    f_a24 = '0;
    f_s4[SENSOR_BITS-1:0] = f_sensor;
    f_a24[ANGLE_BITS-1:0] = f_angle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (angle_strobe && fifo_full &&
                 drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // ---------------- OOTX path ----------------
  // sr keeps only the 7 oldest bits; the live bit completes the byte.
  logic [6:0] sr    [2];
  logic [2:0] cnt   [2];
  logic [7:0] pbyte [2];
  logic [1:0] pend;
  logic [1:0] pend_set;
  logic [1:0] pend_clr;
  logic [7:0] sr_next;
  logic       byte_done;

  assign sr_next = {sr[lighthouse], data};

  always_comb begin
    pend_set  = '0;
    byte_done = data_strobe && (cnt[lighthouse] == 3'd7);
    if (byte_done && !pend[lighthouse]) begin
      pend_set[lighthouse] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sr[i]    <= '0;
        cnt[i]   <= '0;
        pbyte[i] <= '0;
      end
      pend         <= '0;
      ootx_overrun <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
      if (data_strobe) begin
        sr[lighthouse]  <= sr_next[6:0];
        cnt[lighthouse] <= cnt[lighthouse] + 3'd1;
      end
      if (pend_set[lighthouse]) begin
        pbyte[lighthouse] <= sr_next;
      end
      if (byte_done && pend[lighthouse]) begin
        ootx_overrun <= 1'b1;
      end
    end
  end

  // ---------------- arbiter + send FSM ----------------
  state_e      state;
  state_e      state_d;
  grant_e      last_grant;
  logic        req_a;
  logic        req_o;
  logic        o_sel;
  logic        grant_a;
  logic        grant_o;
  logic [31:0] angle_pkt;
  logic [31:0] ootx_pkt;
  logic [31:0] pkt;
  logic [31:0] load_pkt;
  logic [1:0]  load_last;
  logic        load;
  logic        advance;
  logic [1:0]  idx;
  logic [1:0]  last;

  assign req_a = !fifo_empty;
  assign req_o = |pend;
  assign o_sel = pend[0] ? 1'b0 : 1'b1;

  // On contention the source opposite the previous winner goes next.
  assign grant_a = req_a && (!req_o || last_grant == G_OOTX);
  assign grant_o = req_o && !grant_a;

  assign angle_pkt = {PKT_ANGLE, f_lh, f_axis, f_s4, f_a24};
  assign ootx_pkt  = {ootx_hdr(o_sel), pbyte[o_sel], 16'h0000};

  always_comb begin
    state_d   = state;
    load      = 1'b0;
    load_pkt  = '0;
    load_last = '0;
    fifo_rd   = 1'b0;
    pend_clr  = '0;
    advance   = 1'b0;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          grant_a: begin
            load      = 1'b1;
            load_pkt  = angle_pkt;
            load_last = 2'(ANGLE_LEN - 1);
            fifo_rd   = 1'b1;
            state_d   = S_SEND;
          end
          grant_o: begin
            load            = 1'b1;
            load_pkt        = ootx_pkt;
            load_last       = 2'(OOTX_LEN - 1);
            pend_clr[o_sel] = 1'b1;
            state_d         = S_SEND;
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
      S_SEND: begin
        if (tx.out_ready) begin
          advance = 1'b1;
          if (idx == last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= G_OOTX;
    end else begin
      state <= state_d;
      if (load) begin
        last_grant <= grant_a ? G_ANGLE : G_OOTX;
      end
    end
  end

  // Byte 0 sits in the top lane; each accepted byte shifts the next up.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt  <= '0;
      idx  <= '0;
      last <= '0;
    end else if (load) begin
      pkt  <= load_pkt;
      idx  <= '0;
      last <= load_last;
    end else if (advance) begin
      pkt <= {pkt[23:0], 8'h00};
      idx <= idx + 2'd1;
    end
  end

  assign tx.out_data  = pkt[31:24];
  assign tx.out_valid = (state == S_SEND);

endmodule

// File: tb/tb_lighthouse_report_scheduler.sv
// Self-checking bench for lighthouse_report_scheduler.
// Directed vector table, corner sequences, then random traffic vs a queue model.
module tb_lighthouse_report_scheduler;

  localparam int SB    = 4;
  localparam int AB    = 20;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          angle_strobe;
  logic [AB-1:0] angle;
  logic [SB-1:0] sensor;
  logic          lighthouse;
  logic          axis;
  logic          data_strobe;
  logic          data;
  logic          rdy;
  logic [7:0]    drop_count;
  logic          ootx_overrun;

  lighthouse_report_scheduler_if bus();
  assign bus.out_ready = rdy;

  lighthouse_report_scheduler #(
    .SENSORS     (1),
    .SENSOR_BITS (SB),
    .ANGLE_BITS  (AB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .angle_strobe (angle_strobe),
    .angle        (angle),
    .sensor       (sensor),
    .lighthouse   (lighthouse),
    .axis         (axis),
    .data_strobe  (data_strobe),
    .data         (data),
    .tx           (bus),
    .drop_count   (drop_count),
    .ootx_overrun (ootx_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a_s, input logic l, input logic x,
                       input logic [3:0] s, input logic [19:0] a,
                       input logic d_s, input logic d);
    angle_strobe = a_s;
    lighthouse   = l;
    axis         = x;
    sensor       = s;
    angle        = a;
    data_strobe  = d_s;
    data         = d;
    @(negedge clk);
    angle_strobe = 1'b0;
    data_strobe  = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    angle_strobe = 1'b0;
    data_strobe  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset drop_count", drop_count, 0);
    chk("reset ootx_overrun", ootx_overrun, 0);
    reset = 1'b0;
  endtask

  logic [7:0] got [$];

  task automatic collect(input string name, input int n, input int budget);
    int cyc;
    got.delete();
    cyc = 0;
    while (got.size() < n && cyc < budget) begin
      if (bus.out_valid && rdy) got.push_back(bus.out_data);
      @(negedge clk);
      cyc++;
    end
    chk({name, " byte count"}, got.size(), n);
  endtask

  task automatic cmp_got(input string name, input logic [7:0] exp [$]);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size())
        chk($sformatf("%s byte%0d", name, i), got[i], exp[i]);
    end
  endtask

  task automatic quiet(input string name, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    chk({name, " no residual bytes"}, seen, 0);
  endtask

  function automatic logic [31:0] pkt_of(input logic l, input logic x,
                                         input logic [3:0] s,
                                         input logic [19:0] a);
    return (32'h2 << 30) | (32'(l) << 29) | (32'(x) << 28) |
           (32'(s) << 24) | 32'(a);
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       lh;
    logic       ax;
    logic [3:0] s;
    logic [19:0] a;
  } smp_t;

  smp_t       m_aq [$];
  logic [7:0] m_pk [$];
  logic       m_busy;
  logic [1:0] m_pend;
  logic [7:0] m_pb [2];
  logic [7:0] m_sr [2];
  int         m_cnt [2];
  int         m_drop;
  logic       m_ovr;
  logic       m_last_ootx;

  task automatic model_reset();
    m_aq.delete();
    m_pk.delete();
    m_busy      = 0;
    m_pend      = 0;
    m_drop      = 0;
    m_ovr       = 0;
    m_last_ootx = 1;
    for (int i = 0; i < 2; i++) begin
      m_pb[i]  = 0;
      m_sr[i]  = 0;
      m_cnt[i] = 0;
    end
  endtask

  // One clock of the scheduler's rules, all decisions on pre-edge state.
  task automatic model_step(input logic a_s, input smp_t smp,
                            input logic d_s, input logic d,
                            input logic r);
    logic       full;
    logic [1:0] pend_pre;
    logic       sel;
    logic [31:0] w;
    smp_t       e;
    full     = (m_aq.size() == DEPTH);
    pend_pre = m_pend;
    if (m_busy) begin
      if (r) begin
        void'(m_pk.pop_front());
        if (m_pk.size() == 0) m_busy = 0;
      end
    end else begin
      if (m_aq.size() != 0 && (pend_pre == 0 || m_last_ootx)) begin
        e = m_aq.pop_front();
        w = pkt_of(e.lh, e.ax, e.s, e.a);
        for (int k = 3; k >= 0; k--) m_pk.push_back(8'(w >> (8 * k)));
        m_busy      = 1;
        m_last_ootx = 0;
      end else if (pend_pre != 0) begin
        sel = pend_pre[0] ? 1'b0 : 1'b1;
        m_pk.push_back(8'hC0 | (8'(sel) << 5));
        m_pk.push_back(m_pb[sel]);
        m_pend[sel] = 0;
        m_busy      = 1;
        m_last_ootx = 1;
      end
    end
    if (a_s) begin
      if (full) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_aq.push_back(smp);
      end
    end
    if (d_s) begin
      m_sr[smp.lh] = {m_sr[smp.lh][6:0], d};
      m_cnt[smp.lh]++;
      if (m_cnt[smp.lh] == 8) begin
        m_cnt[smp.lh] = 0;
        if (pend_pre[smp.lh]) m_ovr = 1;
        else begin
          m_pb[smp.lh]   = m_sr[smp.lh];
          m_pend[smp.lh] = 1;
        end
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        lh;
    logic        ax;
    logic [3:0]  s;
    logic [19:0] a;
    logic [31:0] e;
  } vec_t;

  vec_t vt [4];

  initial begin
    logic [7:0] exp [$];
    logic [7:0] bb;
    smp_t       smp;
    logic       a_s;
    logic       d_s;
    logic       d;

    vt[0] = '{1'b1, 1'b0, 4'd3,  20'hABCDE, 32'hA30ABCDE};
    vt[1] = '{1'b0, 1'b1, 4'd15, 20'hFFFFF, 32'h9F0FFFFF};
    vt[2] = '{1'b0, 1'b0, 4'd0,  20'h00000, 32'h80000000};
    vt[3] = '{1'b1, 1'b1, 4'd5,  20'h12345, 32'hB5012345};

    rdy          = 1'b1;
    angle_strobe = 1'b0;
    data_strobe  = 1'b0;
    angle        = '0;
    sensor       = '0;
    lighthouse   = 1'b0;
    axis         = 1'b0;
    data         = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    do_reset();

    // Single angle packets: header at N+2, one byte per cycle, gap after.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vt[i].lh, vt[i].ax, vt[i].s, vt[i].a, 1'b0, 1'b0);
      chk($sformatf("vec%0d N+1 idle", i), bus.out_valid, 0);
      for (int b = 0; b < 4; b++) begin
        logic [31:0] ev;
        ev = vt[i].e;
        @(negedge clk);
        chk($sformatf("vec%0d valid b%0d", i, b), bus.out_valid, 1);
        chk($sformatf("vec%0d data b%0d", i, b), bus.out_data,
            8'(ev >> (24 - 8 * b)));
      end
      @(negedge clk);
      chk($sformatf("vec%0d gap", i), bus.out_valid, 0);
    end

    // OOTX byte on lighthouse A.
    bb = 8'hB2;
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 0, 1, bb[7-k]);
    collect("ootx A", 2, 20);
    exp = '{8'hC0, 8'hB2};
    cmp_got("ootx A", exp);
    chk("ootx A overrun", ootx_overrun, 0);

    // Contention after reset: angle first, then OOTX; again angle next time.
    do_reset();
    bb = 8'h6E;
    for (int k = 0; k < 7; k++) drive(0, 0, 0, 0, 0, 1, bb[7-k]);
    drive(1, 0, 1, 4'd2, 20'h00123, 1, bb[0]);
    collect("contend1", 6, 30);
    exp = '{8'h92, 8'h00, 8'h01, 8'h23, 8'hC0, 8'h6E};
    cmp_got("contend1", exp);
    bb = 8'h81;
    for (int k = 0; k < 7; k++) drive(0, 0, 0, 0, 0, 1, bb[7-k]);
    drive(1, 0, 0, 4'd7, 20'hFEDCB, 1, bb[0]);
    collect("contend2", 6, 30);
    exp = '{8'h87, 8'h0F, 8'hED, 8'hCB, 8'hC0, 8'h81};
    cmp_got("contend2", exp);

    // FIFO overflow while the sink stalls.
    rdy = 1'b0;
    do_reset();
    drive(1, 0, 0, 4'd1, 20'h00001, 0, 0);
    @(negedge clk);
    chk("fill header valid", bus.out_valid, 1);
    chk("fill header data", bus.out_data, 8'h81);
    for (int i = 0; i < 10; i++)
      drive(1, 1, 1, 4'(i), 20'(i * 3 + 5), 0, 0);
    repeat (3) @(negedge clk);
    chk("fill drop_count", drop_count, 2);
    chk("fill held valid", bus.out_valid, 1);
    chk("fill held data", bus.out_data, 8'h81);
    rdy = 1'b1;
    collect("fill drain", 36, 120);
    exp = '{8'h81, 8'h00, 8'h00, 8'h01};
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = pkt_of(1, 1, 4'(i), 20'(i * 3 + 5));
      for (int k = 3; k >= 0; k--) exp.push_back(8'(w >> (8 * k)));
    end
    cmp_got("fill drain", exp);
    chk("fill drop after drain", drop_count, 2);
    quiet("fill", 10);

    // OOTX overrun: second byte arrives while the first is still pending.
    rdy = 1'b0;
    do_reset();
    drive(1, 1, 0, 4'd3, 20'hABCDE, 0, 0);
    @(negedge clk);
    chk("ovr angle valid", bus.out_valid, 1);
    bb = 8'h5A;
    for (int k = 0; k < 8; k++) drive(0, 1, 0, 0, 0, 1, bb[7-k]);
    chk("ovr after byte1", ootx_overrun, 0);
    bb = 8'h3C;
    for (int k = 0; k < 8; k++) drive(0, 1, 0, 0, 0, 1, bb[7-k]);
    chk("ovr after byte2", ootx_overrun, 1);
    rdy = 1'b1;
    collect("ovr drain", 6, 30);
    exp = '{8'hA3, 8'h0A, 8'hBC, 8'hDE, 8'hE0, 8'h5A};
    cmp_got("ovr drain", exp);
    quiet("ovr", 12);

    // Reset in the middle of a packet.
    rdy = 1'b0;
    do_reset();
    drive(1, 1, 0, 4'd3, 20'hABCDE, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 4'd1, 20'(i), 0, 0);
    chk("midrst drop before", drop_count, 2);
    rdy = 1'b1;
    @(negedge clk);
    chk("midrst byte2 data", bus.out_data, 8'h0A);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst valid", bus.out_valid, 0);
    chk("midrst drop", drop_count, 0);
    chk("midrst overrun", ootx_overrun, 0);
    reset = 1'b0;
    quiet("midrst", 30);

    // Random traffic against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000 && errors < 40; c++) begin
      chk($sformatf("rnd c%0d valid", c), bus.out_valid, m_busy);
      if (m_busy)
        chk($sformatf("rnd c%0d data", c), bus.out_data, m_pk[0]);
      chk($sformatf("rnd c%0d drop", c), drop_count, m_drop);
      chk($sformatf("rnd c%0d overrun", c), ootx_overrun, m_ovr);
      smp.lh = 1'($urandom);
      smp.ax = 1'($urandom);
      smp.s  = 4'($urandom);
      smp.a  = 20'($urandom);
      d      = 1'($urandom);
      if (c < 2500) begin
        rdy = ($urandom_range(0, 9) < 7);
        a_s = ($urandom_range(0, 9) < 3);
        d_s = ($urandom_range(0, 9) < 4);
      end else if (c < 2800) begin
        rdy = 1'b0;
        a_s = 1'b1;
        d_s = ($urandom_range(0, 9) < 2);
      end else begin
        rdy = 1'b1;
        a_s = ($urandom_range(0, 9) < 1);
        d_s = ($urandom_range(0, 9) < 1);
      end
      angle_strobe = a_s;
      lighthouse   = smp.lh;
      axis         = smp.ax;
      sensor       = smp.s;
      angle        = smp.a;
      data_strobe  = d_s;
      data         = d;
      model_step(a_s, smp, d_s, d, rdy);
      @(negedge clk);
    end
    angle_strobe = 1'b0;
    data_strobe  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

endmodule
